mem_dump_engine: RTL

//  Synthesizable data-memory dump engine for the RISC-V MicroArquitectura.
//  On a halt trigger (fetched instruction == 0) or an external start, it takes

---
 rtl/mem_dump_engine.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_dump_engine.sv
// Data-memory dump engine: on a halt or start trigger it takes over the memory
// read port, walks a word range and streams {addr, data} beats over valid/ready.
module mem_dump_engine #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       inst_i,
   input  logic              halt_en_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [CNT_W-1:0]  word_count_i,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              core_stall_o,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [ADDR_W-1:0] dump_addr_o,
   output logic [DATA_W-1:0] dump_data_o,
   output logic              dump_last_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned SPAN  = DEPTH * BYTES;
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BYTES);
   localparam logic [ADDR_W-1:0] WRAP       = ADDR_W'(SPAN);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BYTES - 1));
   localparam logic [2:0]        LAT_M1     = 3'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_OUT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d, addr_sum, addr_inc;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [2:0]        wcnt_q, wcnt_d;
   logic              halt_src_q, halt_src_d;
   logic              start_q1, start_q2;
   logic              halt_trig, start_rise, trigger;

   // start_i comes from outside the core clock domain logic; register it twice
   // and detect the rising edge on the registered copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         start_q1 <= 1'b0;
         start_q2 <= 1'b0;
      end else begin
         start_q1 <= start_i;
         start_q2 <= start_q1;
      end
   end

   assign halt_trig  = halt_en_i & (inst_i == 32'd0);
   assign start_rise = start_q1 & ~start_q2;
   assign trigger    = halt_trig | start_rise;

   assign addr_sum = addr_q + STEP;
   assign addr_inc = (addr_sum >= WRAP) ? addr_sum - WRAP : addr_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         data_q     <= '0;
         wcnt_q     <= '0;
         halt_src_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         data_q     <= data_d;
         wcnt_q     <= wcnt_d;
         halt_src_q <= halt_src_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      data_d       = data_q;
      wcnt_d       = wcnt_q;
      halt_src_d   = halt_src_q;
      mem_rd_en_o  = 1'b0;
      dump_valid_o = 1'b0;
      busy_o       = 1'b0;
      done_o       = 1'b0;
      core_stall_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (trigger) begin
               addr_d     = start_addr_i & ALIGN_MASK;
               rem_d      = word_count_i;
               halt_src_d = halt_trig;
               state_d    = (word_count_i == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            busy_o       = 1'b1;
            core_stall_o = 1'b1;
            mem_rd_en_o  = 1'b1;
            wcnt_d       = '0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            busy_o       = 1'b1;
            core_stall_o = 1'b1;
            if (wcnt_q == LAT_M1) begin
               data_d  = mem_rdata_i;
               state_d = S_OUT;
            end else begin
               wcnt_d = wcnt_q + 3'd1;
            end
         end
         S_OUT: begin
            busy_o       = 1'b1;
            core_stall_o = 1'b1;
            dump_valid_o = 1'b1;
            if (dump_ready_i) begin
               addr_d  = addr_inc;
               rem_d   = rem_q - CNT_W'(1);
               state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            done_o       = 1'b1;
            core_stall_o = halt_src_q;
            // Leave only once the trigger source has gone away, so a held
            // halt or start cannot immediately re-fire.
            if ((!halt_en_i || inst_i != 32'd0) && !start_i) begin
               halt_src_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_addr_o  = busy_o ? addr_q : '0;
   assign dump_addr_o = dump_valid_o ? addr_q : '0;
   assign dump_data_o = dump_valid_o ? data_q : '0;
   assign dump_last_o = dump_valid_o & (rem_q == CNT_W'(1));

endmodule
